multi_buffer_stream: RTL

- Parametrised single-clock N-deep frame buffer (N ≥ 3, default triple) with internal buffer-rotation management.
- The writer fills fixed-length frames of DEPTH words and is never blocked.
- The reader, on request, always gets the most recently completed frame, streamed out with valid/ready backpressure.
- Sits between the ETS sample capture path and the AXI-Stream readout.
- Replaces externally driven one-hot buffer selection with self-managed ownership, frame-complete flags and a dropped-frame counter.

---
 rtl/multi_buffer_stream.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/multi_buffer_stream.sv
// N-bank frame buffer with self-managed bank rotation: the writer is never blocked, and the reader
// always streams the newest committed frame with valid/ready backpressure.
module multi_buffer_stream #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 448,
  parameter int ADDR_W  = 9,
  parameter int NUM_BUF = 3,
  parameter int DROP_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               w_valid,
  input  logic [DATA_W-1:0]  w_data,
  input  logic               w_abort,
  output logic               w_frame_done,
  output logic [NUM_BUF-1:0] w_buf_id,
  input  logic               r_req,
  output logic               r_valid,
  output logic [DATA_W-1:0]  r_data,
  input  logic               r_ready,
  output logic               r_last,
  output logic               r_busy,
  output logic [NUM_BUF-1:0] r_buf_id,
  output logic               fresh,
  output logic [DROP_W-1:0]  drop_cnt
);

  localparam int BIDX_W = $clog2(NUM_BUF);
  localparam logic [ADDR_W-1:0] LAST_WA = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   LAST_RA = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0]   END_RA  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {RD_IDLE, RD_PRIME, RD_STREAM} rd_state_t;

  logic [DATA_W-1:0] mem [0:NUM_BUF*(2**ADDR_W)-1];
  logic [DATA_W-1:0] rd_q;

  logic [BIDX_W-1:0] w_bank;
  logic [ADDR_W-1:0] wa;
  logic [BIDX_W-1:0] latest;
  logic [BIDX_W-1:0] r_bank;
  logic [ADDR_W:0]   ra;
  rd_state_t         rd_state;

  logic              commit;
  logic              fresh_post;
  logic              req_acc;
  logic [BIDX_W-1:0] lock_bank;
  logic              rd_hold;
  logic [BIDX_W-1:0] rd_hold_bank;
  logic [BIDX_W-1:0] next_bank;
  logic              rd_xfer;
  logic              fetch;

  assign commit       = w_valid && !w_abort && (wa == LAST_WA);
  assign fresh_post   = fresh || commit;
  // A request coinciding with a commit sees the just-committed bank as latest.
  assign lock_bank    = commit ? w_bank : latest;
  assign req_acc      = r_req && !r_busy && fresh_post;
  assign rd_hold      = req_acc || r_busy;
  assign rd_hold_bank = req_acc ? lock_bank : r_bank;
  assign rd_xfer      = r_valid && r_ready;
  assign fetch        = (rd_state == RD_STREAM) && (!r_valid || r_ready) && (ra != END_RA);

  // Lowest bank that is neither the bank being committed nor held by the reader.
  always_comb begin
    next_bank = '0;
    for (int i = NUM_BUF - 1; i >= 0; i--) begin
      if ((BIDX_W'(i) != w_bank) && !(rd_hold && (BIDX_W'(i) == rd_hold_bank))) begin
        next_bank = BIDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_valid && !w_abort) begin
      mem[{w_bank, wa}] <= w_data;
    end
    if (fetch) begin
      rd_q <= mem[{r_bank, ra[ADDR_W-1:0]}];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_bank       <= '0;
      wa           <= '0;
      latest       <= '0;
      fresh        <= 1'b0;
      drop_cnt     <= '0;
      w_frame_done <= 1'b0;
    end else begin
      w_frame_done <= commit;
      if (w_abort) begin
        wa <= '0;
      end else if (w_valid) begin
        if (commit) begin
          wa     <= '0;
          w_bank <= next_bank;
          latest <= w_bank;
          if (fresh && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
          end
        end else begin
          wa <= wa + 1'b1;
        end
      end
      if (req_acc) begin
        fresh <= 1'b0;
      end else if (commit) begin
        fresh <= 1'b1;
      end
    end
  end

  // PRIME spends one cycle so the first word appears two cycles after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state <= RD_IDLE;
      r_busy   <= 1'b0;
      r_bank   <= '0;
      ra       <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (req_acc) begin
            rd_state <= RD_PRIME;
            r_busy   <= 1'b1;
            r_bank   <= lock_bank;
            ra       <= '0;
          end
        end
        RD_PRIME: begin
          rd_state <= RD_STREAM;
        end
        RD_STREAM: begin
          if (fetch) begin
            r_valid <= 1'b1;
            r_last  <= (ra == LAST_RA);
            ra      <= ra + 1'b1;
          end else if (rd_xfer) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
          end
          if (rd_xfer && r_last) begin
            rd_state <= RD_IDLE;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  assign r_data = r_valid ? rd_q : '0;

  generate
    for (genvar gi = 0; gi < NUM_BUF; gi++) begin : g_onehot
      assign w_buf_id[gi] = (w_bank == BIDX_W'(gi));
      assign r_buf_id[gi] = r_busy && (r_bank == BIDX_W'(gi));
    end
  endgenerate

endmodule
